// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage of the pipelined MIPS datapath.
// Word-addressed RAM with a configurable multi-cycle access latency. While
// an access is in flight the pipeline is stalled. When the access completes,
// load data (or the pre-store word) is returned in a one-cycle DONE window.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT                  state;
  stateT                  nextState;

  logic [31:0]            mem [DEPTH];

  logic [3:0]             count;
  logic                   opWrite;
  logic [DEPTH_LOG2-1:0]  idxLatched;
  logic [31:0]            dataLatched;
  logic                   misLatched;

  logic                   req;
  logic [DEPTH_LOG2-1:0]  wordIdx;
  logic                   accept;
  logic                   access;
  logic                   countDown;
  logic                   unusedAddrBits;

  assign req            = memreadM | memwriteM;
  assign wordIdx        = aluoutM[DEPTH_LOG2+1:2];
  assign unusedAddrBits = ^aluoutM[31:DEPTH_LOG2+2];

  // Next-state and stall decode. The stall is held low while reset is asserted.
  always_comb begin
    nextState = state;
    stallM    = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    countDown = 1'b0;
    case (state)
      IDLE: begin
        stallM = req;
        if (req) begin
          nextState = BUSY;
          accept    = 1'b1;
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (!req) begin
          nextState = IDLE;
        end else if (count == 4'd0) begin
          nextState = DONE;
          access    = 1'b1;
        end else begin
          countDown = 1'b1;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (!reset) begin
      stallM = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Latency counter: loaded on acceptance, counts down while the request holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (accept) begin
      count <= CNT_INIT;
    end else if (countDown) begin
      count <= count - 4'd1;
    end
  end

  // Capture the request once accepted; later input changes are not looked at.
  always_ff @(posedge clk) begin
    if (accept) begin
      opWrite     <= memwriteM;
      idxLatched  <= wordIdx;
      dataLatched <= writedataM;
      misLatched  <= (aluoutM[1:0] != 2'b00);
    end
  end

  // Response registers: old/read word or zero plus a one-cycle misalign flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdataM <= 32'd0;
      misalignM <= 1'b0;
    end else begin
      misalignM <= 1'b0;
      if (access) begin
        if (misLatched) begin
          readdataM <= 32'd0;
          misalignM <= 1'b1;
        end else begin
          readdataM <= mem[idxLatched];
        end
      end
    end
  end

  // Memory write port; contents survive reset and a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (reset && access && opWrite && !misLatched) begin
      mem[idxLatched] <= dataLatched;
    end
  end

endmodule
